// File: rtl/mips_ifetch.sv
// MIPS instruction fetch stage: PC sequencing, instruction memory handshake and IF/ID register.
// Define MIPS_IF_FLUSH_EN to squash the instruction after a redirect; otherwise it runs as a delay slot.
module mips_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  pcsrc,
  input  logic        br_taken,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  typedef enum logic {FETCH, HELD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        redir_q;
  logic [31:0] tgt_q;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc4;

  logic        consume;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc4;
  logic        ack_fire;
  logic        pc_update;
  logic [31:0] next_pc;
  logic        squash;

  always_comb begin
    consume  = id_valid && !stall;
    redirect = 1'b0;
    target   = jpc;
    case (pcsrc)
      2'b00: begin
        redirect = 1'b0;
        target   = jpc;
      end
      2'b01: begin
        redirect = consume && br_taken;
        target   = bpc;
      end
      2'b10: begin
        redirect = consume;
        target   = rpc;
      end
      2'b11: begin
        redirect = consume;
        target   = jpc;
      end
    endcase
    pc4       = pc + 32'd4;
    // An ack only counts against a request we actually issued.
    ack_fire  = (state == FETCH) && imem_req && imem_ack;
    pc_update = (ack_fire && !stall) || ((state == HELD) && !stall);
    next_pc   = redirect ? target : (redir_q ? tgt_q : pc4);
`ifdef MIPS_IF_FLUSH_EN
    // The word landing with (or after) a redirect is the sequential one; drop it.
    squash    = redirect || redir_q;
`else
    squash    = 1'b0;
`endif
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= {RESET_PC[31:2], 2'b00};
      imem_req  <= 1'b0;
      id_inst   <= 32'd0;
      id_pc4    <= 32'd0;
      id_valid  <= 1'b0;
      redir_q   <= 1'b0;
      tgt_q     <= 32'd0;
      skid_inst <= 32'd0;
      skid_pc4  <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          imem_req <= 1'b1;
          if (ack_fire) begin
            if (stall) begin
              skid_inst <= imem_rdata;
              skid_pc4  <= pc4;
              imem_req  <= 1'b0;
              state     <= HELD;
            end else begin
              id_inst  <= imem_rdata;
              id_pc4   <= pc4;
              id_valid <= !squash;
            end
          end else if (!stall) begin
            id_valid <= 1'b0;
          end
        end
        HELD: begin
          if (!stall) begin
            id_inst  <= skid_inst;
            id_pc4   <= skid_pc4;
            id_valid <= !squash;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
      endcase

      // pc moves only on a completed fetch, so the request address stays stable.
      if (pc_update) begin
        pc      <= {next_pc[31:2], 2'b00};
        redir_q <= 1'b0;
      end else if (redirect) begin
        redir_q <= 1'b1;
        tgt_q   <= target;
      end
    end
  end

endmodule

// File: tb/tb_mips_ifetch.sv
// Directed bench for mips_ifetch: reset, streaming, skid hold, branch/jr/j redirects, wrap and mid-fetch reset.
module tb_mips_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pcsrc;
  logic        br_taken;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;

  int ncmp = 0;
  int nfail = 0;

`ifdef MIPS_IF_FLUSH_EN
  localparam logic FLUSH = 1'b1;
`else
  localparam logic FLUSH = 1'b0;
`endif

  always #5 clk = ~clk;

  // Memory returns a word derived from its address so every fetch is identifiable.
  assign imem_rdata = imem_addr ^ 32'hCAFE_0000;

  mips_ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pcsrc(pcsrc), .br_taken(br_taken),
    .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; pcsrc = 2'b00; br_taken = 1'b0;
    bpc = 32'd0; rpc = 32'd0; jpc = 32'd0; imem_ack = 1'b1;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    chk("rst_pc4", id_pc4, 32'd0);

    // Release; zero-wait memory acks every cycle.
    rst_n = 1'b1;
    tick();
    chk("e1_req", {31'd0, imem_req}, 32'd1);
    chk("e1_addr", imem_addr, 32'h0);
    chk("e1_valid", {31'd0, id_valid}, 32'd0);
    tick();
    chk("e2_valid", {31'd0, id_valid}, 32'd1);
    chk("e2_pc4", id_pc4, 32'h4);
    chk("e2_inst", id_inst, 32'hCAFE_0000);
    chk("e2_addr", imem_addr, 32'h4);
    tick();
    chk("e3_addr", imem_addr, 32'h8);
    chk("e3_pc4", id_pc4, 32'h8);
    tick();
    chk("e4_addr", imem_addr, 32'hC);

    // Ack under stall: park 0xC, hold IF/ID (inst at 0x8) for three cycles.
    stall = 1'b1;
    tick();
    chk("held_req", {31'd0, imem_req}, 32'd0);
    chk("held_pc4", id_pc4, 32'hC);
    tick(); tick();
    chk("held_inst", id_inst, 32'hCAFE_0008);
    chk("held_valid", {31'd0, id_valid}, 32'd1);
    stall = 1'b0;
    tick();
    chk("unpark_inst", id_inst, 32'hCAFE_000C);
    chk("unpark_pc4", id_pc4, 32'h10);
    chk("unpark_addr", imem_addr, 32'h10);
    chk("unpark_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("br_inst", id_inst, 32'hCAFE_0010);
    chk("br_addr", imem_addr, 32'h14);

    // Taken branch at 0x10 to 0x40.
    pcsrc = 2'b01; br_taken = 1'b1; bpc = 32'h40;
    tick();
    pcsrc = 2'b00; br_taken = 1'b0;
    chk("slot_pc4", id_pc4, 32'h18);
    chk("slot_valid", {31'd0, id_valid}, {31'd0, ~FLUSH});
    chk("br_target", imem_addr, 32'h40);
    tick();
    chk("tgt_inst", id_inst, 32'hCAFE_0040);
    chk("tgt_addr", imem_addr, 32'h44);

    // jr to 0x80 while the 0x44 fetch waits two cycles for its ack.
    imem_ack = 1'b0; pcsrc = 2'b10; rpc = 32'h80;
    tick();
    pcsrc = 2'b00;
    chk("jr_addr_hold", imem_addr, 32'h44);
    chk("jr_bubble", {31'd0, id_valid}, 32'd0);
    chk("jr_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("jr_addr_hold2", imem_addr, 32'h44);
    imem_ack = 1'b1;
    tick();
    chk("jr_target", imem_addr, 32'h80);
    chk("jr_slot_pc4", id_pc4, 32'h48);
    chk("jr_slot_valid", {31'd0, id_valid}, {31'd0, ~FLUSH});
    tick();
    chk("jr_tgt_inst", id_inst, 32'hCAFE_0080);

    // j to the last word, then sequential wrap to 0.
    pcsrc = 2'b11; jpc = 32'hFFFF_FFFC;
    tick();
    pcsrc = 2'b00;
    chk("j_target", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", id_pc4, 32'h0);
    chk("wrap_inst", id_inst, 32'h3501_FFFC);
    chk("wrap_valid", {31'd0, id_valid}, 32'd1);
    tick();
    chk("post_wrap_addr", imem_addr, 32'h4);

    // Reset pulsed while the 0x4 request waits; the late ack must be ignored.
    imem_ack = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_pc4", id_pc4, 32'h0);
    imem_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("late_ack_valid", {31'd0, id_valid}, 32'd0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'h0);
    tick();
    chk("refetch_pc4", id_pc4, 32'h4);
    chk("refetch_valid", {31'd0, id_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
